// File: rtl/fp_div_scheduler.sv
// Round-robin arbiter sharing one iterative FP divider among NUM_REQ requesters.
// Optional watchdog enabled by defining DIV_TIMEOUT_EN.
module fp_div_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [NUM_REQ*32-1:0] resp_z,
  output logic [NUM_REQ-1:0]    resp_err,
  output logic                  div_start,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic                  div_done,
  input  logic [31:0]           div_result
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        owner_q;
  logic                 div_start_q;
  logic [31:0]          div_a_q;
  logic [31:0]          div_b_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [31:0]          resp_z_q [NUM_REQ];

  logic [31:0]          req_a_s [NUM_REQ];
  logic [31:0]          req_b_s [NUM_REQ];
  logic [NUM_REQ-1:0]   elig_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [IW-1:0]        gidx_s;
  logic                 gany_s;
  logic [IW:0]          sum_s;
  logic [IW-1:0]        idx_s;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]        tmo_q;
  logic [NUM_REQ-1:0]   resp_err_q;
`endif

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    if (cur == IW'(NUM_REQ - 1)) begin
      return {IW{1'b0}};
    end else begin
      return cur + IW'(1);
    end
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a_s[g]          = req_a[32*g +: 32];
    assign req_b_s[g]          = req_b[32*g +: 32];
    assign resp_z[32*g +: 32]  = resp_z_q[g];
  end

  // A requester still holding an unread result is not eligible.
  assign elig_s = (state_q == S_IDLE) ? (req_valid & ~resp_valid_q) : {NUM_REQ{1'b0}};

  // Rotating priority scan starting at rr_ptr_q; first eligible index wins.
  always_comb begin
    grant_s = {NUM_REQ{1'b0}};
    gidx_s  = {IW{1'b0}};
    gany_s  = 1'b0;
    sum_s   = {(IW+1){1'b0}};
    idx_s   = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s  = {1'b0, rr_ptr_q} + (IW+1)'(k);
      idx_s  = (sum_s >= (IW+1)'(NUM_REQ)) ? IW'(sum_s - (IW+1)'(NUM_REQ)) : IW'(sum_s);
      gidx_s = (elig_s[idx_s] && !gany_s) ? idx_s : gidx_s;
      grant_s[idx_s] = elig_s[idx_s] & ~gany_s;
      gany_s = gany_s | elig_s[idx_s];
    end
  end

  assign req_ready  = grant_s;
  assign resp_valid = resp_valid_q;
  assign div_start  = div_start_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
`ifdef DIV_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = {NUM_REQ{1'b0}};
`endif

  // Scheduler FSM plus response buffers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= {IW{1'b0}};
      owner_q      <= {IW{1'b0}};
      div_start_q  <= 1'b0;
      div_a_q      <= 32'h0000_0000;
      div_b_q      <= 32'h0000_0000;
      resp_valid_q <= {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) resp_z_q[i] <= 32'h0000_0000;
`ifdef DIV_TIMEOUT_EN
      tmo_q        <= {CW{1'b0}};
      resp_err_q   <= {NUM_REQ{1'b0}};
`endif
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid_q[i] && resp_ready[i]) begin
          resp_valid_q[i] <= 1'b0;
`ifdef DIV_TIMEOUT_EN
          resp_err_q[i]   <= 1'b0;
`endif
        end
      end
      case (state_q)
        S_IDLE: begin
          div_start_q <= 1'b0;
          if (gany_s) begin
            div_a_q     <= req_a_s[gidx_s];
            div_b_q     <= req_b_s[gidx_s];
            owner_q     <= gidx_s;
            div_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          div_start_q <= 1'b0;
          state_q     <= S_WAIT;
`ifdef DIV_TIMEOUT_EN
          // The issue cycle counts as the first elapsed cycle.
          tmo_q       <= CW'(1);
`endif
        end
        S_WAIT: begin
          div_start_q <= 1'b0;
          if (div_done) begin
            resp_z_q[owner_q]     <= div_result;
            resp_valid_q[owner_q] <= 1'b1;
            rr_ptr_q              <= next_idx(owner_q);
            state_q               <= S_IDLE;
`ifdef DIV_TIMEOUT_EN
          end else if (tmo_q >= CW'(TIMEOUT_CYCLES - 1)) begin
            resp_z_q[owner_q]     <= 32'h7FC0_0000;
            resp_valid_q[owner_q] <= 1'b1;
            resp_err_q[owner_q]   <= 1'b1;
            rr_ptr_q              <= next_idx(owner_q);
            state_q               <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + CW'(1);
`endif
          end
        end
        default: begin
          div_start_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_scheduler.sv
// Randomized bench for fp_div_scheduler with a transaction-level reference model.
// Define DIV_TIMEOUT_EN for both files to exercise the watchdog.
module tb_fp_div_scheduler;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [N*32-1:0] req_a, req_b, resp_z;
  logic            div_start, div_done;
  logic [31:0]     div_a, div_b, div_result;

  fp_div_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z), .resp_err(resp_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, buffered results, one in-flight operation.
  logic [N-1:0] pending, m_hold, m_err, rdy_ctl;
  logic [31:0]  pa [N];
  logic [31:0]  pb [N];
  logic [31:0]  m_z [N];
  logic [31:0]  m_a, m_b;
  int           m_rr, m_phase, m_owner, m_lat, m_tmo;
  bit           rand_mode, no_done;
  int           glog [$];
  int           step_no, start_cnt, start_step, rise_step;
  logic         prev_rv0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (pending[idx] && !m_hold[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pick_special();
    case ($urandom_range(4))
      0:       return 32'h7FC0_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h0000_0000;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_clear();
    pending = '0; m_hold = '0; m_err = '0;
    m_rr = 0; m_phase = 0; m_owner = 0; m_lat = 0; m_tmo = 0;
    for (int i = 0; i < N; i++) m_z[i] = 32'h0;
  endtask

  task automatic step();
    int g;
    logic [31:0] exp_rdy;
    @(negedge Clk);
    step_no++;
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!pending[i] && $urandom_range(2) == 0) begin
          pending[i] = 1'b1; pa[i] = $urandom; pb[i] = $urandom;
        end
      resp_ready = N'($urandom);
    end else begin
      resp_ready = rdy_ctl;
    end
    req_valid = pending;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = pa[i];
      req_b[32*i +: 32] = pb[i];
    end
    div_done = 1'b0;
    div_result = $urandom;
    if (m_phase == 2) begin
      if (!no_done) begin
        m_lat--;
        if (m_lat == 0) begin
          div_done = 1'b1;
          div_result = rand_mode ? pick_special() : m_a;
        end
      end
    end else if ($urandom_range(7) == 0) begin
      div_done = 1'b1;
    end
    #1;
    g = pick();
    exp_rdy = 32'h0;
    if (m_phase == 0 && g >= 0) exp_rdy = 32'(1) << g;
    check_eq("req_ready", 32'(req_ready), exp_rdy);
    check_eq("resp_valid", 32'(resp_valid), 32'(m_hold));
    check_eq("resp_err", 32'(resp_err), 32'(m_err));
    check_eq("div_start", 32'(div_start), 32'(m_phase == 1));
    if (m_phase == 1) begin
      check_eq("div_a", div_a, m_a);
      check_eq("div_b", div_b, m_b);
    end
    for (int i = 0; i < N; i++) check_eq("resp_z", resp_z[32*i +: 32], m_z[i]);
    if (div_start) begin start_cnt++; start_step = step_no; end
    if (resp_valid[0] && !prev_rv0) rise_step = step_no;
    prev_rv0 = resp_valid[0];
    for (int i = 0; i < N; i++)
      if (m_hold[i] && resp_ready[i]) begin m_hold[i] = 1'b0; m_err[i] = 1'b0; end
    case (m_phase)
      0: if (g >= 0) begin
           m_phase = 1; m_owner = g; m_a = pa[g]; m_b = pb[g];
           pending[g] = 1'b0; glog.push_back(g);
         end
      1: begin
           m_phase = 2; m_lat = rand_mode ? int'($urandom_range(5, 1)) : 2; m_tmo = TMO - 1;
         end
      2: if (div_done) begin
           m_hold[m_owner] = 1'b1; m_z[m_owner] = div_result;
           m_rr = (m_owner + 1) % N; m_phase = 0;
         end
`ifdef DIV_TIMEOUT_EN
         else begin
           m_tmo--;
           if (m_tmo == 0) begin
             m_hold[m_owner] = 1'b1; m_err[m_owner] = 1'b1; m_z[m_owner] = 32'h7FC0_0000;
             m_rr = (m_owner + 1) % N; m_phase = 0;
           end
         end
`endif
      default: m_phase = 0;
    endcase
  endtask

  task automatic run_until(input int n);
    int b;
    for (b = 0; b < 400 && !(glog.size() >= n && m_phase == 0); b++) step();
    check_eq("run_bound", 32'(glog.size() >= n && m_phase == 0), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    req_valid = '0; div_done = 1'b0;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_err", 32'(resp_err), 32'h0);
    check_eq("rst_div_start", 32'(div_start), 32'h0);
    check_eq("rst_div_a", div_a, 32'h0);
    check_eq("rst_div_b", div_b, 32'h0);
    for (int i = 0; i < N; i++) check_eq("rst_resp_z", resp_z[32*i +: 32], 32'h0);
    model_clear();
    prev_rv0 = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    div_done = 1'b0; div_result = 32'h0;
    rand_mode = 1'b0; no_done = 1'b0; rdy_ctl = '0;
    step_no = 0; start_cnt = 0; start_step = 0; rise_step = 0;
    for (int i = 0; i < N; i++) begin pa[i] = 32'h0; pb[i] = 32'h0; end
    do_reset();

    // Single request, result held unread.
    pending[0] = 1'b1; pa[0] = 32'h4040_0000; pb[0] = 32'h3F80_0000;
    run_until(1);
    step();
    check_eq("t1_start_cnt", 32'(start_cnt), 32'h1);
    check_eq("t1_valid", 32'(resp_valid[0]), 32'h1);
    check_eq("t1_z", resp_z[31:0], 32'h4040_0000);
    check_eq("t1_err", 32'(resp_err[0]), 32'h0);
    rdy_ctl = '1;
    repeat (3) step();

    // Reset while the divider is busy: no response after release.
    pending[1] = 1'b1; pa[1] = 32'h4100_0000; pb[1] = 32'h4000_0000;
    for (int b = 0; b < 20 && m_phase != 2; b++) step();
    check_eq("t5_in_wait", 32'(m_phase), 32'h2);
    do_reset();
    repeat (10) step();

    // All four at once from rr_ptr=0.
    glog.delete();
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b1; pa[i] = 32'h4000_0000 + 32'(i) * 32'h0010_0000; pb[i] = 32'h3F80_0000;
    end
    rdy_ctl = '0;
    run_until(4);
    step();
    for (int i = 0; i < 4; i++) check_eq("t2_order", 32'(glog[i]), 32'(i));
    check_eq("t2_slots", 32'(resp_valid), 32'hF);
    rdy_ctl = '1;
    repeat (3) step();

    // Requester 1 holding its result is skipped until it is consumed.
    glog.delete();
    rdy_ctl = 4'b1101;
    pending[1] = 1'b1; pa[1] = 32'h3F00_0000; pb[1] = 32'h4000_0000;
    run_until(1);
    pending[3] = 1'b1; pa[3] = 32'h4080_0000;
    run_until(2);
    pending[1] = 1'b1; pa[1] = 32'h4110_0000;
    pending[2] = 1'b1; pa[2] = 32'h4120_0000;
    run_until(3);
    repeat (4) step();
    check_eq("t3_skip", 32'(glog.size()), 32'h3);
    rdy_ctl = '1;
    run_until(4);
    check_eq("t3_o0", 32'(glog[0]), 32'h1);
    check_eq("t3_o1", 32'(glog[1]), 32'h3);
    check_eq("t3_o2", 32'(glog[2]), 32'h2);
    check_eq("t3_o3", 32'(glog[3]), 32'h1);

    // Random traffic with random consumers, latencies and stray div_done pulses.
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;

`ifdef DIV_TIMEOUT_EN
    do_reset();
    glog.delete();
    rdy_ctl = '0; no_done = 1'b1;
    pending[0] = 1'b1; pa[0] = 32'h4040_0000; pb[0] = 32'h3F80_0000;
    run_until(1);
    step();
    check_eq("t6_z", resp_z[31:0], 32'h7FC0_0000);
    check_eq("t6_err", 32'(resp_err[0]), 32'h1);
    check_eq("t6_latency", 32'(rise_step - start_step), 32'(TMO));
    no_done = 1'b0; rdy_ctl = '1;
    repeat (3) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
